i2s_tx_multi: RTL and testbench
===============================

# i2s_tx_multi

Parametrised successor to the fixed 16-bit stereo codec serialiser behind `audio_top`. It accepts whole sample frames over a valid/ready handshake into a small frame FIFO. It generates the bit clock and frame clock from `clk`, and shifts samples MSB-first to the audio CODEC. It supports configurable sample width, slot width and channel count (stereo I2S or TDM), selectable I2S or left-justified framing, and underrun reporting.

## Interface
- `DATA_WIDTH`, 16: bits per sample; 8..32.
- `SLOTS`, 2: channels per frame; 2 gives LR-clock framing, 4/6/8 gives TDM with frame-sync pulse.
- `SLOT_BITS`, 32: bit-clock periods per slot; must be ≥ DATA_WIDTH; unused LSB positions are sent as 0.
- `BCLK_HALF`, 4: `clk` cycles per bit-clock half period; ≥ 2.
- `FIFO_DEPTH`, 4: frames held; power of two, ≥ 2.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run serialiser; low holds the serial outputs idle.
- `mode` in 1: 0 = I2S (one-bit delay after frame edge), 1 = left-justified; sampled only at frame start.
- `sample_data` in SLOTS*DATA_WIDTH: slot 0 in the LSBs; slot 0 is left.
- `sample_valid` in 1: frame present.
- `sample_ready` out 1: FIFO can accept a frame.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: frames stored.
- `underrun` out 1: one-`clk` pulse when a frame starts with the FIFO empty.
- `aud_bclk` out 1: bit clock.
- `aud_lrck` out 1: LR clock (SLOTS=2) or frame sync (SLOTS>2).
- `aud_dat` out 1: serial data.

## Operation
- **FIFO**
  - A push occurs on `sample_valid && sample_ready`.
  - `sample_ready = (fifo_level != FIFO_DEPTH)`, registered.
  - Push and pop in the same cycle: the level is unchanged and both take effect.
  - A pop from an empty FIFO is never performed. The frame is loaded as all-zero and `underrun` pulses. A push in that same cycle is stored normally.
- **Divider**
  - The divider counter runs 0..BCLK_HALF-1 and toggles `aud_bclk` on wrap.
  - A falling `aud_bclk` edge is the "shift tick".
- **Frame counter**
  - The bit index runs 0..SLOTS*SLOT_BITS-1 and advances on each shift tick.
  - At index 0 the next frame is popped into the shift register and `mode` is latched.
  - Each slot is built as {sample, (SLOT_BITS-DATA_WIDTH) zeros}.
- **Data output**
  - Left-justified: `aud_dat` = shift-register MSB, updated on each shift tick.
  - I2S: `aud_dat` is the same stream delayed by exactly one shift tick. Bit index 0 therefore carries the final bit of the previous frame, which is 0 after reset.
- **LR/frame clock**
  - SLOTS=2: `aud_lrck` = 0 during slot 0 and 1 during slot 1; it changes on shift ticks.
  - SLOTS>2: `aud_lrck` = 1 for the bit period at index 0 only, otherwise 0.
  - In I2S mode with SLOTS>2, the sync pulse is also delayed one bit, aligning it with the MSB.
- **Enable low**
  - Divider, bit index and delay register are cleared.
  - `aud_bclk`, `aud_lrck` and `aud_dat` are 0.
  - No pops and no underrun.
  - The FIFO keeps accepting frames.
  - Dropping `enable` mid-frame abandons the current frame; the next rise restarts at index 0 with a fresh pop.
- **Reset (`rst_n` low)**
  - `aud_bclk`, `aud_lrck`, `aud_dat` = 0.
  - `underrun` = 0.
  - `fifo_level` = 0.
  - `sample_ready` = 1, valid from the first cycle after deassertion.
  - FIFO contents are discarded.
  - Reset mid-frame truncates output immediately.

## Timing
- Bit period = 2*BCLK_HALF `clk` cycles; frame period = SLOTS*SLOT_BITS bit periods.
- All outputs are registered; serial outputs change only on the `clk` edge that produces the falling edge of `aud_bclk`.
- The first falling `aud_bclk` occurs BCLK_HALF*2 cycles after `enable` rises; that tick is index 0.
- Push-to-`fifo_level` update: 1 cycle.
- `sample_ready` deasserts in the cycle after the push that fills the FIFO.
- A pop at a shift tick frees a slot visible one cycle later.
- `underrun` is asserted in the same cycle as the index-0 shift tick.

## Test plan
- **Reset values**: hold `rst_n` low 5 cycles with `enable`=1 → all serial outputs 0, `fifo_level`=0, `sample_ready`=1, no `underrun`.
- **Left-justified stereo** (defaults except SLOT_BITS=16, mode=1): push {16'h1234, 16'hA5C3} → `aud_lrck` low for 16 bits carrying A5C3 MSB-first, then high for 16 bits carrying 1234. Bit period is 8 clk.
- **I2S delay** (mode=0, same data): MSB of A5C3 appears one bit after `aud_lrck` falls; index 0 carries 0 after reset.
- **Underrun**: enable with FIFO empty → `underrun` pulses once per frame, `aud_dat` stays 0. Push one frame mid-frame → it plays next frame and `underrun` stops for that frame.
- **Back-pressure**: hold `enable`=0 and push 5 frames → 4 accepted, `sample_ready`=0, `fifo_level`=4. Enable → the first pop raises `sample_ready` one cycle later.
- **TDM** (SLOTS=4, SLOT_BITS=32, DATA_WIDTH=24, mode=1): frame sync is high for bit 0 only, and each slot carries 24 data bits followed by 8 zeros. Deasserting `enable` at bit 50 → outputs go to 0 next cycle; re-enable restarts at slot 0 with the next FIFO frame.

Source files
------------

// File: rtl/i2s_tx_multi.sv
// i2s_tx_multi: frame FIFO feeding an MSB-first I2S / left-justified / TDM serialiser
module i2s_tx_multi #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOTS      = 2,
   parameter int SLOT_BITS  = 32,
   parameter int BCLK_HALF  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          mode,
   input  logic [SLOTS*DATA_WIDTH-1:0]   sample_data,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic                          aud_bclk,
   output logic                          aud_lrck,
   output logic                          aud_dat
);
   localparam int FW = SLOTS*DATA_WIDTH;
   localparam int W  = SLOTS*SLOT_BITS;
   localparam int IW = $clog2(W);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(BCLK_HALF);
   logic [FW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0]   level_n;
   logic [CW-1:0] div;
   logic [IW-1:0] idx;
   logic [W-1:0]  sr, cur, frame;
   logic mode_r, dly, tick, start, empty, push, pop, bit_out, lj, lr_n, wrap;
   assign push    = sample_valid && sample_ready;
   assign empty   = fifo_level == '0;
   assign wrap    = div == CW'(BCLK_HALF-1);
   assign tick    = enable && aud_bclk && wrap;
   assign start   = tick && idx == '0;
   assign pop     = start && !empty;
   assign level_n = fifo_level + (PW+1)'(push) - (PW+1)'(pop);
   // An empty FIFO at frame start plays an all-zero frame instead of popping
   always_comb begin
      frame = '0;
      for (int s = 0; s < SLOTS; s++)
         frame[W-1-s*SLOT_BITS -: DATA_WIDTH] = empty ? '0 : mem[rp][s*DATA_WIDTH +: DATA_WIDTH];
   end
   assign cur     = start ? frame : sr;
   assign lj      = start ? mode : mode_r;
   assign bit_out = cur[W-1];
   assign lr_n    = (SLOTS == 2) ? (idx >= IW'(SLOT_BITS)) : (idx == (lj ? IW'(0) : IW'(1)));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         div      <= '0;
         idx      <= '0;
         sr       <= '0;
         mode_r   <= 1'b0;
         dly      <= 1'b0;
         underrun <= 1'b0;
         aud_bclk <= 1'b0;
         aud_lrck <= 1'b0;
         aud_dat  <= 1'b0;
      end else if (!enable) begin
         div      <= '0;
         idx      <= '0;
         dly      <= 1'b0;
         underrun <= 1'b0;
         aud_bclk <= 1'b0;
         aud_lrck <= 1'b0;
         aud_dat  <= 1'b0;
      end else begin
         underrun <= start && empty;
         div      <= wrap ? '0 : div + CW'(1);
         if (wrap) aud_bclk <= !aud_bclk;
         if (tick) begin
            idx      <= idx == IW'(W-1) ? '0 : idx + IW'(1);
            sr       <= cur << 1;
            mode_r   <= lj;
            dly      <= bit_out;
            aud_dat  <= lj ? bit_out : dly;
            aud_lrck <= lr_n;
         end
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp           <= '0;
         rp           <= '0;
         fifo_level   <= '0;
         sample_ready <= 1'b1;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop) rp <= rp + PW'(1);
         fifo_level   <= level_n;
         sample_ready <= level_n != (PW+1)'(FIFO_DEPTH);
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= sample_data;
endmodule

// File: tb/tb_i2s_tx_multi.sv
// tb_i2s_tx_multi: stereo instance checked against a frame-level model every cycle,
// plus a TDM instance checked with hand-built expected bit streams.
module tb_i2s_tx_multi;
   logic clk, rst_n;
   logic a_en, a_mode, a_valid, a_ready, a_und, a_bclk, a_lrck, a_dat;
   logic [31:0] a_data;
   logic [2:0]  a_lvl;
   logic b_en, b_mode, b_valid, b_ready, b_und, b_bclk, b_lrck, b_dat;
   logic [95:0] b_data;
   logic [2:0]  b_lvl;
   int n_cmp = 0, n_bad = 0;
   logic chk = 0;

   i2s_tx_multi #(.DATA_WIDTH(16), .SLOTS(2), .SLOT_BITS(16), .BCLK_HALF(4), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(a_en), .mode(a_mode), .sample_data(a_data),
      .sample_valid(a_valid), .sample_ready(a_ready), .fifo_level(a_lvl), .underrun(a_und),
      .aud_bclk(a_bclk), .aud_lrck(a_lrck), .aud_dat(a_dat));

   i2s_tx_multi #(.DATA_WIDTH(24), .SLOTS(4), .SLOT_BITS(32), .BCLK_HALF(2), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(b_en), .mode(b_mode), .sample_data(b_data),
      .sample_valid(b_valid), .sample_ready(b_ready), .fifo_level(b_lvl), .underrun(b_und),
      .aud_bclk(b_bclk), .aud_lrck(b_lrck), .aud_dat(b_dat));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic cmp(input string n, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   // Frame-level model of the stereo instance: bit time counted from enable,
   // frames as whole words in a queue, I2S as the previous serial bit.
   int ph, pos;
   logic [31:0] q[$];
   logic [31:0] m_frame;
   logic m_mode, m_prev, m_bit, acc;
   logic e_bclk, e_lrck, e_dat, e_und, e_rdy;
   logic [2:0] e_lvl;
   always @(posedge clk) begin
      if (!rst_n) begin
         ph = 0; q.delete(); m_frame = 0; m_mode = 0; m_prev = 0;
         e_bclk = 0; e_lrck = 0; e_dat = 0; e_und = 0; e_rdy = 1; e_lvl = 0;
      end else begin
         acc = a_valid && q.size() != 4;
         e_und = 0;
         if (!a_en) begin
            ph = 0; e_bclk = 0; e_lrck = 0; e_dat = 0; m_prev = 0;
         end else begin
            ph++;
            e_bclk = ((ph / 4) % 2) == 1;
            if (ph % 8 == 0) begin
               pos = (ph / 8 - 1) % 32;
               if (pos == 0) begin
                  m_mode = a_mode;
                  if (q.size() == 0) begin e_und = 1; m_frame = 0; end
                  else m_frame = q.pop_front();
               end
               m_bit = m_frame[(pos / 16) * 16 + 15 - pos % 16];
               e_dat = m_mode ? m_bit : m_prev;
               m_prev = m_bit;
               e_lrck = pos >= 16;
            end
         end
         if (acc) q.push_back(a_data);
         e_lvl = 3'(q.size());
         e_rdy = q.size() != 4;
      end
   end

   always @(negedge clk) if (chk) begin
      cmp("a_bclk", a_bclk, e_bclk);
      cmp("a_lrck", a_lrck, e_lrck);
      cmp("a_dat", a_dat, e_dat);
      cmp("a_underrun", a_und, e_und);
      cmp("a_level", a_lvl, e_lvl);
      cmp("a_ready", a_ready, e_rdy);
   end

   typedef struct { logic m; logic [31:0] d; logic [31:0] dat; logic [31:0] lr; } vec_t;
   vec_t tv[4];

   function automatic logic [127:0] tdm_exp(input logic [95:0] f);
      logic [127:0] r = '0;
      for (int s = 0; s < 4; s++)
         for (int k = 0; k < 24; k++) r[127 - s*32 - k] = f[s*24 + 23 - k];
      return r;
   endfunction

   task automatic cap_b(input int n, input logic m_after, output logic [127:0] d,
                        output logic [127:0] l, output logic u0);
      d = '0; l = '0; u0 = 0;
      for (int i = 0; i < n; i++) begin
         repeat (4) @(negedge clk);
         d[127-i] = b_dat;
         l[127-i] = b_lrck;
         if (i == 0) begin u0 = b_und; b_mode = m_after; end
      end
   endtask

   logic [31:0] cd, cl;
   logic [127:0] d, l, e2;
   logic [95:0] f1, f2, f3;
   logic u0;
   int cnt, anyd;

   initial begin
      tv[0] = '{1'b1, 32'h1234_A5C3, 32'hA5C3_1234, 32'h0000_FFFF};
      tv[1] = '{1'b0, 32'h1234_A5C3, 32'h52E1_891A, 32'h0000_FFFF};
      tv[2] = '{1'b1, 32'h8001_FFFF, 32'hFFFF_8001, 32'h0000_FFFF};
      tv[3] = '{1'b0, 32'h0001_8000, 32'h4000_0000, 32'h0000_FFFF};
      rst_n = 1; a_en = 1; a_mode = 1; a_valid = 0; a_data = 0;
      b_en = 1; b_mode = 1; b_valid = 0; b_data = 0;
      #2 rst_n = 0;
      @(posedge clk); #1 chk = 1;
      repeat (5) step;
      cmp("rst_a_serial", {a_bclk, a_lrck, a_dat, a_und}, 0);
      cmp("rst_a_ready_level", {a_ready, a_lvl}, 4'b1000);
      cmp("rst_b_serial", {b_bclk, b_lrck, b_dat, b_und}, 0);
      cmp("rst_b_ready_level", {b_ready, b_lvl}, 4'b1000);
      a_en = 0; b_en = 0;
      step;
      rst_n = 1;
      step;

      for (int r = 0; r < 4; r++) begin
         a_mode = tv[r].m; a_data = tv[r].d; a_valid = 1;
         step;
         a_valid = 0;
         step;
         a_en = 1;
         for (int i = 0; i < 32; i++) begin
            repeat (8) @(negedge clk);
            cd[31-i] = a_dat;
            cl[31-i] = a_lrck;
         end
         #1 a_en = 0;
         cmp($sformatf("tv%0d_dat", r), cd, tv[r].dat);
         cmp($sformatf("tv%0d_lrck", r), cl, tv[r].lr);
         step;
      end

      a_mode = 1; a_en = 1; cnt = 0; anyd = 0;
      repeat (512) begin @(negedge clk); cnt += int'(a_und); anyd += int'(a_dat); end
      cmp("underrun_count_empty", cnt, 2);
      cmp("underrun_dat_zero", anyd, 0);
      repeat (100) @(negedge clk);
      #1 a_data = 32'hBEEF_DEAD; a_valid = 1;
      step;
      a_valid = 0; cnt = 0;
      repeat (256) begin @(negedge clk); cnt += int'(a_und); end
      cmp("underrun_count_fed", cnt, 0);

      #1 a_en = 0;
      step;
      a_valid = 1;
      for (int i = 0; i < 5; i++) begin a_data = $urandom; step; end
      a_valid = 0;
      cmp("bp_ready_full", a_ready, 0);
      cmp("bp_level_full", a_lvl, 4);
      a_en = 1;
      repeat (7) @(negedge clk);
      cmp("bp_ready_before_pop", a_ready, 0);
      @(negedge clk);
      cmp("bp_ready_after_pop", a_ready, 1);
      cmp("bp_level_after_pop", a_lvl, 3);
      #1;

      for (int c = 0; c < 3000; c++) begin
         a_valid = $urandom_range(0, 149) == 0;
         a_data = $urandom;
         if ($urandom_range(0, 99) == 0) a_mode = ~a_mode;
         if ($urandom_range(0, 499) == 0) a_en = ~a_en;
         step;
      end
      a_valid = 0; a_en = 0;

      f1 = {$urandom, $urandom, $urandom};
      f2 = {$urandom, $urandom, $urandom};
      f3 = {$urandom, $urandom, $urandom};
      f2[29] = 1'b1;
      b_mode = 1; b_valid = 1;
      b_data = f1; step;
      b_data = f2; step;
      b_data = f3; step;
      b_valid = 0;
      cmp("tdm_level_loaded", b_lvl, 3);
      b_en = 1;
      cap_b(128, 1, d, l, u0);
      cmp("tdm_f1_dat", d, tdm_exp(f1));
      cmp("tdm_f1_sync", l, 128'h1 << 127);
      cmp("tdm_f1_underrun", u0, 0);
      cmp("tdm_level_after_pop", b_lvl, 2);
      cap_b(51, 1, d, l, u0);
      e2 = tdm_exp(f2);
      e2[76:0] = '0;
      cmp("tdm_f2_partial_dat", d, e2);
      repeat (2) @(negedge clk);
      cmp("tdm_mid_bit_state", {b_bclk, b_dat}, 2'b11);
      #1 b_en = 0;
      @(negedge clk);
      cmp("tdm_disable_idle", {b_bclk, b_lrck, b_dat}, 0);
      #1 b_en = 1;
      cap_b(128, 0, d, l, u0);
      cmp("tdm_f3_dat", d, tdm_exp(f3));
      cmp("tdm_f3_sync", l, 128'h1 << 127);
      cap_b(3, 0, d, l, u0);
      cmp("tdm_i2s_sync_delay", l[127:125], 3'b010);
      cmp("tdm_empty_dat", d[127:125], 3'b000);
      cmp("tdm_empty_underrun", u0, 1);

      #1 a_en = 1; a_mode = 1; a_data = 32'hFFFF_FFFF; a_valid = 1;
      step;
      a_valid = 0;
      repeat (12) step;
      rst_n = 0;
      #1;
      cmp("rst_mid_a", {a_bclk, a_lrck, a_dat, a_lvl}, 0);
      cmp("rst_mid_b", {b_bclk, b_lrck, b_dat, b_lvl}, 0);
      step;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
